tl45_decode: RTL

- Consumer end of the fetch buffer interface: accepts {pc, inst} from the fetch stage, registers a decoded form for the execute stage, and back-pressures fetch.
- Expands CALL and RET into two micro-ops each, holding fetch stalled during the expansion cycle.
- Propagates downstream stall and flush.
- The all-zero instruction is a bubble (NOP).

---
 rtl/tl45_isa_pkg.sv | 45 ++++
 rtl/tl45_imm_ext.sv | 14 +
 rtl/tl45_decode.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tl45_isa_pkg.sv
// TL45 ISA constants and the decoded micro-op bundle
// shared by the decode stage and its helpers.
package tl45_isa_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_LOAD  = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_JMP   = 5'd4;
  localparam logic [4:0] OP_JMPR  = 5'd5;
  localparam logic [4:0] OP_CALL  = 5'd6;
  localparam logic [4:0] OP_RET   = 5'd7;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int IMM_BIT  = 26;
  localparam int ZEXT_BIT = 24;
  localparam int DR_HI    = 23;
  localparam int DR_LO    = 20;
  localparam int SR1_HI   = 19;
  localparam int SR1_LO   = 16;
  localparam int SR2_HI   = 15;
  localparam int SR2_LO   = 12;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [3:0] LINK_REG = 4'd14;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] imm;
    logic        imm_valid;
  } dec_op_t;

  function automatic logic is_simple_op(
    input logic [4:0] op
  );
    return (op >= OP_ADD) && (op <= OP_JMPR);
  endfunction

endpackage

// File: rtl/tl45_imm_ext.sv
// 16-to-32 bit immediate extension; zext selects
// zero-extension, otherwise sign-extension.
module tl45_imm_ext (
  input  logic [15:0] imm16,
  input  logic        zext,
  output logic [31:0] imm32
);

  logic [15:0] upper;

  assign upper = zext ? 16'h0000 : {16{imm16[15]}};
  assign imm32 = {upper, imm16};

endmodule

// File: rtl/tl45_decode.sv
// TL45 decode stage: registers decoded ops and splits CALL/RET
// into two micro-ops. TL45_DECODE_ILLEGAL_EN adds o_buf_illegal.
module tl45_decode
  import tl45_isa_pkg::*;
#(
  parameter logic [3:0] SP_REG = 4'd15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic        o_pipe_stall,
  output logic [31:0] o_buf_pc,
  output logic [4:0]  o_buf_opcode,
  output logic [3:0]  o_buf_dr,
  output logic [3:0]  o_buf_sr1,
  output logic [3:0]  o_buf_sr2,
  output logic [31:0] o_buf_imm,
  output logic        o_buf_imm_valid
`ifdef TL45_DECODE_ILLEGAL_EN
  ,
  output logic        o_buf_illegal
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  logic [0:0]  state;
  dec_op_t     q;
  dec_op_t     hold;
  dec_op_t     base;
  dec_op_t     nxt;
  dec_op_t     nxt_hold;
  logic        go_exp;

  logic [4:0]  opc;
  logic        imm_f;
  logic        zext;
  logic [31:0] imm32;
  logic        bubble;
  logic        is_call;
  logic        is_ret;
  logic        is_simple;
  logic        unused_ok;

  assign opc       = i_buf_inst[OPC_HI:OPC_LO];
  assign imm_f     = i_buf_inst[IMM_BIT];
  assign zext      = i_buf_inst[ZEXT_BIT];
  assign bubble    = (i_buf_inst == 32'h0);
  assign is_call   = (opc == OP_CALL);
  assign is_ret    = (opc == OP_RET);
  assign is_simple = is_simple_op(opc);
  assign unused_ok = i_buf_inst[25];

  tl45_imm_ext u_imm_ext (
    .imm16 (i_buf_inst[IMM_HI:IMM_LO]),
    .zext  (zext),
    .imm32 (imm32)
  );

  // Plain field decode; an immediate displaces sr2.
  always_comb begin
    base           = '0;
    base.pc        = i_buf_pc;
    base.opcode    = opc;
    base.dr        = i_buf_inst[DR_HI:DR_LO];
    base.sr1       = i_buf_inst[SR1_HI:SR1_LO];
    base.sr2       = imm_f ? 4'd0 : i_buf_inst[SR2_HI:SR2_LO];
    base.imm       = imm_f ? imm32 : 32'h0;
    base.imm_valid = imm_f;
  end

  always_comb begin
    nxt      = '0;
    nxt_hold = '0;
    go_exp   = 1'b0;
    unique case (1'b1)
      bubble: begin
        nxt = '0;
      end
      is_call: begin
        nxt.pc          = i_buf_pc;
        nxt.opcode      = OP_STORE;
        nxt.sr1         = SP_REG;
        nxt.sr2         = LINK_REG;
        nxt.imm         = i_buf_pc + 32'd4;
        nxt.imm_valid   = 1'b1;
        nxt_hold        = base;
        nxt_hold.opcode = OP_JMP;
        go_exp          = 1'b1;
      end
      is_ret: begin
        nxt.pc          = i_buf_pc;
        nxt.opcode      = OP_LOAD;
        nxt.dr          = LINK_REG;
        nxt.sr1         = SP_REG;
        nxt_hold.pc     = i_buf_pc;
        nxt_hold.opcode = OP_JMPR;
        nxt_hold.sr1    = LINK_REG;
        go_exp          = 1'b1;
      end
      is_simple: begin
        nxt = base;
      end
      default: begin
        nxt.pc = i_buf_pc;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      q     <= '0;
      hold  <= '0;
    end else if (i_pipe_flush) begin
      state <= ST_IDLE;
      q     <= '0;
      hold  <= '0;
    end else if (!i_pipe_stall) begin
      if (state == ST_EXPAND) begin
        q     <= hold;
        hold  <= '0;
        state <= ST_IDLE;
      end else begin
        q <= nxt;
        if (go_exp) begin
          hold  <= nxt_hold;
          state <= ST_EXPAND;
        end
      end
    end
  end

`ifdef TL45_DECODE_ILLEGAL_EN
  logic nxt_ill;
  logic ill_q;

  assign nxt_ill = (opc > OP_RET);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ill_q <= 1'b0;
    end else if (i_pipe_flush) begin
      ill_q <= 1'b0;
    end else if (!i_pipe_stall) begin
      ill_q <= (state == ST_EXPAND) ? 1'b0 : nxt_ill;
    end
  end

  assign o_buf_illegal = ill_q;
`endif

  assign o_pipe_stall    = i_pipe_stall | (state == ST_EXPAND);
  assign o_buf_pc        = q.pc;
  assign o_buf_opcode    = q.opcode;
  assign o_buf_dr        = q.dr;
  assign o_buf_sr1       = q.sr1;
  assign o_buf_sr2       = q.sr2;
  assign o_buf_imm       = q.imm;
  assign o_buf_imm_valid = q.imm_valid;

endmodule
